// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus stability filter for a slow asynchronous line.
// Emits a one-cycle strobe when the filtered level goes from 1 to 0.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_fall
);

    localparam int              CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_fall;

    // Idle PS/2 lines are high, so everything resets to 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame decode plus E0/F0 prefix folding into key events.
// Optional partial-frame timeout enabled by defining PS2_KBD_RX_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (falling edge with data 0)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling the odd-parity bit
// ST_STOP   | sampling the stop bit, then reporting byte or error
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2clk,
    input  logic       i_ps2data,
    output logic       o_key_event,
    output logic [7:0] o_scancode,
    output logic       o_released,
    output logic       o_extended,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_err
);

    ps2_state_e r_state, w_next;
    logic [1:0] r_data_sync;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_par_ok;
    logic       r_pend_ext, r_pend_rel;
    logic       w_fall, w_data, w_timeout;
    logic       w_stop_fall, w_good, w_err, w_is_prefix;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i_ps2clk),
        .o_fall (w_fall)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_data_sync <= 2'b11;
        else       r_data_sync <= {r_data_sync[0], i_ps2data};
    end
    assign w_data = r_data_sync[1];

`ifdef PS2_KBD_RX_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                               r_to_cnt <= '0;
        else if (r_state == ST_IDLE || w_fall)   r_to_cnt <= '0;
        else                                     r_to_cnt <= r_to_cnt + 1'b1;
    end
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES < 16);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_fall && !w_data)             w_next = ST_DATA;
            ST_DATA:   if (w_fall && r_bit_cnt == 3'd7)   w_next = ST_PARITY;
            ST_PARITY: if (w_fall)                        w_next = ST_STOP;
            ST_STOP:   if (w_fall)                        w_next = ST_IDLE;
            default:                                      w_next = ST_IDLE;
        endcase
        if (w_timeout) w_next = ST_IDLE;
    end

    // Timeout excludes fall cycles, so good byte and error are exclusive.
    always_comb begin
        w_stop_fall = (r_state == ST_STOP) && w_fall;
        w_good      = w_stop_fall && w_data && r_par_ok;
        w_err       = (w_stop_fall && !w_good) || w_timeout;
        w_is_prefix = (r_shift == PS2_PREFIX_EXT) || (r_shift == PS2_PREFIX_REL);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par_ok    <= 1'b0;
            r_pend_ext  <= 1'b0;
            r_pend_rel  <= 1'b0;
            o_key_event <= 1'b0;
            o_scancode  <= '0;
            o_released  <= 1'b0;
            o_extended  <= 1'b0;
            o_rx_valid  <= 1'b0;
            o_rx_byte   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_valid  <= w_good;
            o_frame_err <= w_err;
            o_key_event <= w_good && !w_is_prefix;

            if (w_fall) begin
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    ST_PARITY: r_par_ok <= ^{r_shift, w_data};
                    default:   ;
                endcase
            end

            if (w_err) begin
                r_pend_ext <= 1'b0;
                r_pend_rel <= 1'b0;
            end else if (w_good) begin
                o_rx_byte <= r_shift;
                if (r_shift == PS2_PREFIX_EXT) begin
                    r_pend_ext <= 1'b1;
                end else if (r_shift == PS2_PREFIX_REL) begin
                    r_pend_rel <= 1'b1;
                end else begin
                    o_scancode <= r_shift;
                    o_released <= r_pend_rel;
                    o_extended <= r_pend_ext;
                    r_pend_ext <= 1'b0;
                    r_pend_rel <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: bit-banged PS/2 frames against an expected-event scoreboard.
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic       key_event, released, extended, rx_valid, frame_err;
    logic [7:0] scancode, rx_byte;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2clk    (ps2clk),
        .i_ps2data   (ps2data),
        .o_key_event (key_event),
        .o_scancode  (scancode),
        .o_released  (released),
        .o_extended  (extended),
        .o_rx_valid  (rx_valid),
        .o_rx_byte   (rx_byte),
        .o_frame_err (frame_err)
    );

    // Observed DUT events, sampled on the inactive edge.
    logic [7:0] obs_rx[$];
    logic [9:0] obs_key[$];
    int         obs_err  = 0;
    int         obs_both = 0;

    always @(negedge clk) begin
        if (rx_valid)  obs_rx.push_back(rx_byte);
        if (key_event) obs_key.push_back({scancode, released, extended});
        if (frame_err) obs_err++;
        if (key_event && frame_err) obs_both++;
    end

    // Expected events, pushed when stimulus is driven.
    logic [7:0] exp_rx[$];
    logic [9:0] exp_key[$];
    int         rd_rx  = 0;
    int         rd_key = 0;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2data = bits[i];
            idle(HALF);
            ps2clk = 1'b0;
            idle(HALF);
            ps2clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_bit);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
        send_bits(bits, 11);
        ps2data = 1'b1;
        idle(HALF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(5);
        n_checks++;
        if ({key_event, scancode, released, extended, rx_valid, rx_byte, frame_err} !== 20'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {key_event, scancode, released, extended, rx_valid, rx_byte, frame_err});
        end
        rst = 1'b0;
        idle(50);
        n_checks++;
        if (obs_rx.size() != 0 || obs_key.size() != 0 || obs_err != 0) begin
            n_errors++;
            $display("FAIL reset_idle_events got rx=%0d key=%0d err=%0d required 0/0/0",
                     obs_rx.size(), obs_key.size(), obs_err);
        end
    endtask

    task automatic test_make_code();
        int eb = obs_err;
        logic [7:0] e8;
        logic [9:0] e10;
        exp_rx.push_back(8'h1C);
        exp_key.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b1);
        idle(30);
        n_checks++;
        if (obs_rx.size() - rd_rx != 1 || obs_key.size() - rd_key != 1 || obs_err - eb != 0) begin
            n_errors++;
            $display("FAIL make_code_counts got rx=%0d key=%0d err=%0d required 1/1/0",
                     obs_rx.size() - rd_rx, obs_key.size() - rd_key, obs_err - eb);
        end
        while (exp_rx.size() > 0 && rd_rx < obs_rx.size()) begin
            e8 = exp_rx.pop_front();
            n_checks++;
            if (obs_rx[rd_rx] !== e8) begin
                n_errors++;
                $display("FAIL make_code_rx got %h required %h", obs_rx[rd_rx], e8);
            end
            rd_rx++;
        end
        while (exp_key.size() > 0 && rd_key < obs_key.size()) begin
            e10 = exp_key.pop_front();
            n_checks++;
            if (obs_key[rd_key] !== e10) begin
                n_errors++;
                $display("FAIL make_code_key got %h required %h", obs_key[rd_key], e10);
            end
            rd_key++;
        end
        exp_rx.delete(); exp_key.delete();
        rd_rx = obs_rx.size(); rd_key = obs_key.size();
    endtask

    task automatic test_prefixes();
        int eb = obs_err;
        logic [7:0] seq [6] = '{8'hF0, 8'h29, 8'hE0, 8'hF0, 8'h75, 8'h66};
        logic [7:0] e8;
        logic [9:0] e10;
        foreach (seq[i]) exp_rx.push_back(seq[i]);
        exp_key.push_back({8'h29, 1'b1, 1'b0});
        exp_key.push_back({8'h75, 1'b1, 1'b1});
        exp_key.push_back({8'h66, 1'b0, 1'b0});
        foreach (seq[i]) send_frame(seq[i], 1'b0, 1'b1);
        idle(30);
        n_checks++;
        if (obs_rx.size() - rd_rx != 6 || obs_key.size() - rd_key != 3 || obs_err - eb != 0) begin
            n_errors++;
            $display("FAIL prefix_counts got rx=%0d key=%0d err=%0d required 6/3/0",
                     obs_rx.size() - rd_rx, obs_key.size() - rd_key, obs_err - eb);
        end
        while (exp_rx.size() > 0 && rd_rx < obs_rx.size()) begin
            e8 = exp_rx.pop_front();
            n_checks++;
            if (obs_rx[rd_rx] !== e8) begin
                n_errors++;
                $display("FAIL prefix_rx got %h required %h", obs_rx[rd_rx], e8);
            end
            rd_rx++;
        end
        while (exp_key.size() > 0 && rd_key < obs_key.size()) begin
            e10 = exp_key.pop_front();
            n_checks++;
            if (obs_key[rd_key] !== e10) begin
                n_errors++;
                $display("FAIL prefix_key got %h required %h", obs_key[rd_key], e10);
            end
            rd_key++;
        end
        exp_rx.delete(); exp_key.delete();
        rd_rx = obs_rx.size(); rd_key = obs_key.size();
    endtask

    task automatic test_frame_errors();
        int eb = obs_err;
        logic [7:0] e8;
        logic [9:0] e10;
        send_frame(8'h1C, 1'b1, 1'b1);
        exp_rx.push_back(8'h1C); exp_key.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b1);
        exp_rx.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h29, 1'b0, 1'b0);
        exp_rx.push_back(8'h1C); exp_key.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b1);
        idle(30);
        n_checks++;
        if (obs_rx.size() - rd_rx != 3 || obs_key.size() - rd_key != 2 || obs_err - eb != 2) begin
            n_errors++;
            $display("FAIL frame_err_counts got rx=%0d key=%0d err=%0d required 3/2/2",
                     obs_rx.size() - rd_rx, obs_key.size() - rd_key, obs_err - eb);
        end
        while (exp_rx.size() > 0 && rd_rx < obs_rx.size()) begin
            e8 = exp_rx.pop_front();
            n_checks++;
            if (obs_rx[rd_rx] !== e8) begin
                n_errors++;
                $display("FAIL frame_err_rx got %h required %h", obs_rx[rd_rx], e8);
            end
            rd_rx++;
        end
        while (exp_key.size() > 0 && rd_key < obs_key.size()) begin
            e10 = exp_key.pop_front();
            n_checks++;
            if (obs_key[rd_key] !== e10) begin
                n_errors++;
                $display("FAIL frame_err_key got %h required %h", obs_key[rd_key], e10);
            end
            rd_key++;
        end
        exp_rx.delete(); exp_key.delete();
        rd_rx = obs_rx.size(); rd_key = obs_key.size();
    endtask

    task automatic test_timeout();
        int eb = obs_err;
        int exp_err;
        logic [9:0] e10;
        send_bits({2'b11, 8'h1C, 1'b0}, 4);
        ps2data = 1'b1;
        idle(TIMEOUT_CYCLES + 5);
`ifdef PS2_KBD_RX_TIMEOUT_EN
        exp_err = 1;
`else
        exp_err = 0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(5);
`endif
        n_checks++;
        if (obs_err - eb != exp_err || obs_rx.size() != rd_rx || obs_key.size() != rd_key) begin
            n_errors++;
            $display("FAIL timeout_idle got err=%0d rx=%0d key=%0d required err=%0d rx=0 key=0",
                     obs_err - eb, obs_rx.size() - rd_rx, obs_key.size() - rd_key, exp_err);
        end
        exp_key.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b1);
        idle(30);
        n_checks++;
        if (obs_key.size() - rd_key != 1 || obs_err - eb != exp_err) begin
            n_errors++;
            $display("FAIL timeout_recover_counts got key=%0d err=%0d required 1/%0d",
                     obs_key.size() - rd_key, obs_err - eb, exp_err);
        end
        while (exp_key.size() > 0 && rd_key < obs_key.size()) begin
            e10 = exp_key.pop_front();
            n_checks++;
            if (obs_key[rd_key] !== e10) begin
                n_errors++;
                $display("FAIL timeout_recover_key got %h required %h", obs_key[rd_key], e10);
            end
            rd_key++;
        end
        exp_key.delete();
        rd_rx = obs_rx.size(); rd_key = obs_key.size();
    endtask

    task automatic test_glitch();
        int eb = obs_err;
        logic [9:0] e10;
        ps2data = 1'b0;
        idle(HALF);
        ps2clk = 1'b0;
        idle(3);
        ps2clk = 1'b1;
        idle(HALF);
        exp_key.push_back({8'h29, 1'b0, 1'b0});
        send_frame(8'h29, 1'b0, 1'b1);
        idle(30);
        n_checks++;
        if (obs_key.size() - rd_key != 1 || obs_rx.size() - rd_rx != 1 || obs_err - eb != 0) begin
            n_errors++;
            $display("FAIL glitch_counts got key=%0d rx=%0d err=%0d required 1/1/0",
                     obs_key.size() - rd_key, obs_rx.size() - rd_rx, obs_err - eb);
        end
        while (exp_key.size() > 0 && rd_key < obs_key.size()) begin
            e10 = exp_key.pop_front();
            n_checks++;
            if (obs_key[rd_key] !== e10) begin
                n_errors++;
                $display("FAIL glitch_key got %h required %h", obs_key[rd_key], e10);
            end
            rd_key++;
        end
        exp_key.delete();
        rd_rx = obs_rx.size(); rd_key = obs_key.size();
    endtask

    task automatic test_reset_midframe();
        int eb = obs_err;
        logic [9:0] e10;
        send_bits({2'b11, 8'h5A, 1'b0}, 5);
        rst = 1'b1;
        idle(3);
        n_checks++;
        if ({key_event, rx_valid, frame_err, scancode} !== 11'd0) begin
            n_errors++;
            $display("FAIL midframe_reset_outputs got %h required 0",
                     {key_event, rx_valid, frame_err, scancode});
        end
        rst = 1'b0;
        ps2data = 1'b1;
        idle(60);
        n_checks++;
        if (obs_key.size() != rd_key || obs_rx.size() != rd_rx || obs_err != eb) begin
            n_errors++;
            $display("FAIL midframe_no_pulse got key=%0d rx=%0d err=%0d required 0/0/0",
                     obs_key.size() - rd_key, obs_rx.size() - rd_rx, obs_err - eb);
        end
        exp_key.push_back({8'h1C, 1'b0, 1'b0});
        send_frame(8'h1C, 1'b0, 1'b1);
        idle(30);
        n_checks++;
        if (obs_key.size() - rd_key != 1 || obs_err != eb) begin
            n_errors++;
            $display("FAIL midframe_recover_counts got key=%0d err=%0d required 1/0",
                     obs_key.size() - rd_key, obs_err - eb);
        end
        while (exp_key.size() > 0 && rd_key < obs_key.size()) begin
            e10 = exp_key.pop_front();
            n_checks++;
            if (obs_key[rd_key] !== e10) begin
                n_errors++;
                $display("FAIL midframe_recover_key got %h required %h", obs_key[rd_key], e10);
            end
            rd_key++;
        end
        exp_key.delete();
        rd_rx = obs_rx.size(); rd_key = obs_key.size();
    endtask

    initial begin
        test_reset();
        test_make_code();
        test_prefixes();
        test_frame_errors();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        n_checks++;
        if (obs_both != 0) begin
            n_errors++;
            $display("FAIL key_and_err_same_cycle got %0d required 0", obs_both);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Receives the raw PS/2 keyboard clock/data lines and turns them into decoded key events. Handles line synchronisation and glitch filtering, frame checks, and E0/F0 prefix folding. It sits directly upstream of the key-to-mode decoder and drives its `key_event`/`scancode`/`released`/`extended` inputs. It also exposes raw bytes and frame errors for diagnostics.

## Interface
- `FILTER_LEN`, 8: consecutive equal synchronised samples required before `ps2clk` is taken as changed (2..255).
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles after which a partial frame is abandoned (≥ 16).
- `clk` in 1: system clock, 1–600 MHz.
- `rst` in 1: reset. Asynchronous, active-high.
- `ps2clk` in 1: raw PS/2 clock, asynchronous.
- `ps2data` in 1: raw PS/2 data, asynchronous.
- `key_event` out 1: one-cycle pulse when a complete key code has been decoded.
- `scancode` out 8: final (non-prefix) byte of the last key code. Held until the next `key_event`.
- `released` out 1: 1 if F0 preceded `scancode`. Held with `scancode`.
- `extended` out 1: 1 if E0 preceded `scancode`. Held with `scancode`.
- `rx_valid` out 1: one-cycle pulse for every good byte, prefixes included.
- `rx_byte` out 8: byte qualified by `rx_valid`.
- `frame_err` out 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
- Both lines pass through a 2-FF synchroniser.
- `ps2clk` additionally passes through a filter: the filtered level flips only after `FILTER_LEN` consecutive opposite samples.
- A bit is sampled from synchronised `ps2data` on each falling edge of filtered `ps2clk`.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data 0, go to DATA with the bit count cleared. If data is 1, it is a false start; stay in IDLE with no error.
  - DATA: shift in bits. After the 8th bit, go to PARITY.
  - PARITY: check that the ones-count of data plus parity is odd. Go to STOP and latch a parity-ok flag.
  - STOP: stop=1 and parity ok means a good byte. Anything else pulses `frame_err`. Return to IDLE in either case.
- Good-byte handling:
  - Pulse `rx_valid` for every good byte.
  - Byte = E0: set the pending-ext flag.
  - Byte = F0: set the pending-rel flag.
  - Any other byte: pulse `key_event`, load `scancode`/`released`/`extended` from the byte and the flags, then clear both flags.
- Any `frame_err` clears both pending flags.
- Repeated prefixes (E0 E0, F0 F0) leave the flags set.
- E1 has no special handling and is emitted as an ordinary key code.
- Reset values: all outputs 0, FSM in IDLE, flags clear, filtered clock = 1.

## Timing
- Falling edge recognised at cycle N, where N is the 3rd synchroniser cycle plus `FILTER_LEN` samples after the pin edge.
- Stop bit sampled at cycle N; `rx_valid`, `key_event` and `frame_err` assert at N+1 for exactly one cycle.
- `scancode`, `released` and `extended` update on the same edge that raises `key_event`.
- `key_event` and `frame_err` are never high in the same cycle.
- `rst` asserted mid-frame: immediate return to IDLE, partial byte discarded, no pulse afterwards.
- Filter pulses shorter than `FILTER_LEN` cycles produce no edge.

## Configuration
- `PS2_KBD_RX_TIMEOUT_EN` defined:
  - A counter runs in every non-IDLE state and is cleared on each falling edge.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE, `frame_err` pulses and the flags clear.
- `PS2_KBD_RX_TIMEOUT_EN` undefined:
  - No counter, and `TIMEOUT_CYCLES` is unused.
  - A truncated frame is resolved only by later edges, which may produce a parity or stop error.

## Structure
- Package `ps2_pkg`:
  - FSM state enum.
  - Constants `PS2_PREFIX_EXT` = 8'hE0 and `PS2_PREFIX_REL` = 8'hF0.
- Sub-module `ps2_line_filter`: 2-FF synchroniser, `FILTER_LEN` stability counter, and a one-cycle falling-edge strobe. Instantiated once, for `ps2clk`.

## Test plan
- Frame 0x1C, parity 0, stop 1 → exactly one `key_event`, `scancode`=1C, `released`=0, `extended`=0, and one `rx_valid` with `rx_byte`=1C.
- F0 (parity 1) then 0x29 (parity 0) → two `rx_valid` pulses but a single `key_event`, `scancode`=29, `released`=1, `extended`=0.
- E0, F0, 0x75 (parity 0) → one `key_event`, `scancode`=75, `released`=1, `extended`=1. A following 0x66 (parity 1) gives `released`=0, `extended`=0.
- 0x1C sent with parity 1 → `frame_err` pulse, no `key_event`. A following good 0x1C decodes normally. F0 then a stop-bit-0 frame then 0x1C → `released`=0.
- With the macro: start bit plus 3 data bits, then idle for `TIMEOUT_CYCLES`+5 cycles → one `frame_err`, FSM in IDLE, next 0x1C decodes. Without the macro → no `frame_err` during the idle period.
- 3-cycle low glitch on `ps2clk` (`FILTER_LEN`=8) → no bit sampled. `rst` asserted after the 4th data bit → no output pulses; next frame decodes correctly.
